// File: rtl/cpu_clk_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_clk_ctrl_if
//  Purpose  : Control/status bundle between the FPGA wrapper and the CPU
//             clock and run controller.
//  Signals  : mode_i        2    00 free-run, 01 halt, 10 single-step, 11 burst
//             div_i         DIV  half-period of clk_out_o minus one
//             step_btn_i    1    raw asynchronous step push-button
//             burst_len_i   BW   CPU periods per burst
//             pc_in_i       32   CPU IF-stage PC
//             inst_in_i     32   CPU IF-stage instruction
//             clk_out_o     1    divided CPU clock
//             clk_en_o      1    pulse in the cycle clk_out_o rises
//             running_o     1    controller not halted
//             cycle_count_o 32   CPU rising edges since reset
//             burst_remain_o BW  CPU periods left in the burst
//             pc_snap_o     32   PC captured at the last falling edge
//             inst_snap_o   32   instruction captured at the last falling edge
//  Revision : 1.0  initial release
// ============================================================================
interface cpu_clk_ctrl_if #(
   parameter int DIV_WIDTH   = 32,
   parameter int BURST_WIDTH = 16
);
   logic [1:0]             mode_i;
   logic [DIV_WIDTH-1:0]   div_i;
   logic                   step_btn_i;
   logic [BURST_WIDTH-1:0] burst_len_i;
   logic [31:0]            pc_in_i;
   logic [31:0]            inst_in_i;
   logic                   clk_out_o;
   logic                   clk_en_o;
   logic                   running_o;
   logic [31:0]            cycle_count_o;
   logic [BURST_WIDTH-1:0] burst_remain_o;
   logic [31:0]            pc_snap_o;
   logic [31:0]            inst_snap_o;

   modport master (
      output mode_i, div_i, step_btn_i, burst_len_i, pc_in_i, inst_in_i,
      input  clk_out_o, clk_en_o, running_o, cycle_count_o, burst_remain_o,
             pc_snap_o, inst_snap_o
   );

   modport slave (
      input  mode_i, div_i, step_btn_i, burst_len_i, pc_in_i, inst_in_i,
      output clk_out_o, clk_en_o, running_o, cycle_count_o, burst_remain_o,
             pc_snap_o, inst_snap_o
   );
endinterface
`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_clk_ctrl
//  Purpose  : Divides the board clock into the CPU clock with a runtime
//             ratio, and adds halt, debounced single-step and N-period burst
//             modes plus PC/instruction snapshots for board display.
//  Ports    : clk_gen_i  board clock, the only clock of this block
//             rst_i      synchronous active-high reset
//             bus        cpu_clk_ctrl_if slave (mode/div/button/burst inputs,
//                        clock, status and snapshot outputs)
//  Revision : 1.0  initial release
// ============================================================================
module cpu_clk_ctrl #(
   parameter int DIV_WIDTH   = 32,
   parameter int DB_CYCLES   = 1000000,
   parameter int DB_WIDTH    = 20,
   parameter int BURST_WIDTH = 16
) (
   input wire logic      clk_gen_i,
   input wire logic      rst_i,
   cpu_clk_ctrl_if.slave bus
);

   localparam logic [1:0] c_MODE_FREE  = 2'b00;
   localparam logic [1:0] c_MODE_HALT  = 2'b01;
   localparam logic [1:0] c_MODE_STEP  = 2'b10;
   localparam logic [1:0] c_MODE_BURST = 2'b11;

   localparam logic [DB_WIDTH-1:0] c_DB_LAST = DB_WIDTH'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BURST = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic                   clk_out_q, clk_out_d;
   logic                   clk_en_q, clk_en_d;
   logic                   running_q, running_d;
   logic [31:0]            cycle_count_q, cycle_count_d;
   logic [BURST_WIDTH-1:0] remain_q, remain_d;
   logic [31:0]            pc_snap_q, pc_snap_d;
   logic [31:0]            inst_snap_q, inst_snap_d;

   logic                   sync1_q, sync2_q;
   logic [DB_WIDTH-1:0]    db_cnt_q;
   logic                   db_level_q, db_prev_q;

   logic                   w_press;
   logic                   w_phase;
   logic                   w_rise;
   logic                   w_fall;

   // ------------------------------------------------------------------------
   // Button path: two-flop synchroniser, then a level that only follows the
   // synchronised input once it has held a new value for DB_CYCLES cycles.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_gen_i) begin
      if (rst_i) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         db_cnt_q   <= '0;
         db_level_q <= 1'b0;
         db_prev_q  <= 1'b0;
      end else begin
         sync1_q   <= bus.step_btn_i;
         sync2_q   <= sync1_q;
         db_prev_q <= db_level_q;
         if (sync2_q != db_level_q) begin
            if (db_cnt_q == c_DB_LAST) begin
               db_level_q <= sync2_q;
               db_cnt_q   <= '0;
            end else begin
               db_cnt_q <= db_cnt_q + 1'b1;
            end
         end else begin
            db_cnt_q <= '0;
         end
      end
   end

   assign w_press = db_level_q & ~db_prev_q;

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_gen_i) begin
      if (rst_i) begin
         state_q       <= ST_HALT;
         cnt_q         <= '0;
         div_q         <= '0;
         clk_out_q     <= 1'b0;
         clk_en_q      <= 1'b0;
         running_q     <= 1'b0;
         cycle_count_q <= '0;
         remain_q      <= '0;
         pc_snap_q     <= '0;
         inst_snap_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         div_q         <= div_d;
         clk_out_q     <= clk_out_d;
         clk_en_q      <= clk_en_d;
         running_q     <= running_d;
         cycle_count_q <= cycle_count_d;
         remain_q      <= remain_d;
         pc_snap_q     <= pc_snap_d;
         inst_snap_q   <= inst_snap_d;
      end
   end

   // ------------------------------------------------------------------------
   // Divider, mode control and snapshot next-state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      div_d         = div_q;
      clk_out_d     = clk_out_q;
      clk_en_d      = 1'b0;
      cycle_count_d = cycle_count_q;
      remain_d      = remain_q;
      pc_snap_d     = pc_snap_q;
      inst_snap_d   = inst_snap_q;

      // The ratio in force is the one latched at the last phase event (or at
      // entry), so a mid-count DIV change never truncates a half-period.
      w_phase = (state_q != ST_HALT) && (cnt_q == div_q);
      w_rise  = w_phase && !clk_out_q;
      w_fall  = w_phase && clk_out_q;

      if (state_q != ST_HALT) begin
         if (w_phase) begin
            cnt_d     = '0;
            div_d     = bus.div_i;
            clk_out_d = ~clk_out_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (w_rise) begin
         clk_en_d      = 1'b1;
         cycle_count_d = cycle_count_q + 32'd1;
      end

      if (w_fall) begin
         pc_snap_d   = bus.pc_in_i;
         inst_snap_d = bus.inst_in_i;
      end

      // Every stop happens on a falling phase event, so the clock always
      // parks low and a high phase is never cut short by a mode change.
      case (state_q)
         ST_HALT: begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            div_d     = bus.div_i;
            case (bus.mode_i)
               c_MODE_FREE: state_d = ST_RUN;
               c_MODE_STEP: begin
                  if (w_press) state_d = ST_STEP;
               end
               c_MODE_BURST: begin
                  if (w_press && (bus.burst_len_i != '0)) begin
                     state_d  = ST_BURST;
                     remain_d = bus.burst_len_i;
                  end
               end
               c_MODE_HALT: state_d = ST_HALT;
               default:     state_d = ST_HALT;
            endcase
         end
         ST_RUN: begin
            if (w_fall && (bus.mode_i != c_MODE_FREE)) state_d = ST_HALT;
         end
         ST_STEP: begin
            // Entered with the clock low: the first fall ends the one period.
            if (w_fall) state_d = ST_HALT;
         end
         ST_BURST: begin
            if (w_fall) begin
               if (bus.mode_i == c_MODE_HALT) begin
                  state_d  = ST_HALT;
                  remain_d = '0;
               end else begin
                  remain_d = remain_q - 1'b1;
                  if (remain_q == BURST_WIDTH'(1)) state_d = ST_HALT;
               end
            end
         end
         default: state_d = ST_HALT;
      endcase

      running_d = (state_d != ST_HALT);
   end

   assign bus.clk_out_o      = clk_out_q;
   assign bus.clk_en_o       = clk_en_q;
   assign bus.running_o      = running_q;
   assign bus.cycle_count_o  = cycle_count_q;
   assign bus.burst_remain_o = remain_q;
   assign bus.pc_snap_o      = pc_snap_q;
   assign bus.inst_snap_o    = inst_snap_q;

endmodule
`default_nettype wire

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Parametrised clock and run controller for the FPGA top level of the RV32IM pipeline. It divides the board clock CLK_GEN into the CPU clock, with a runtime-programmable ratio. It adds halt, debounced single-step and N-cycle burst modes, and captures PC/INST snapshots for board display. It replaces the fixed free-running divider in the FPGA wrapper and drives the clock of the cpu, imem and dmem instances.

## Interface
Parameters:
- DIV_WIDTH, 32, width of the divide register and divider counter
- DB_CYCLES, 1000000, CLK_GEN cycles the synchronised button must be stable to register
- DB_WIDTH, 20, width of the debounce counter; must satisfy 2^DB_WIDTH > DB_CYCLES
- BURST_WIDTH, 16, width of the burst length and remaining count

Ports:
- CLK_GEN  in  1  board clock; the only clock of this block
- RST  in  1  reset, synchronous, active-high
- MODE  in  2  00 free-run, 01 halt, 10 single-step, 11 burst
- DIV  in  DIV_WIDTH  half-period of CLK_OUT minus one, in CLK_GEN cycles
- STEP_BTN  in  1  raw asynchronous push-button, active-high
- BURST_LEN  in  BURST_WIDTH  number of CPU clock periods per burst
- PC_IN  in  32  CPU IF-stage PC
- INST_IN  in  32  CPU IF-stage instruction
- CLK_OUT  out  1  divided CPU clock (registered)
- CLK_EN  out  1  one-cycle pulse in the CLK_GEN cycle where CLK_OUT goes 0->1
- RUNNING  out  1  high when state is not HALT
- CYCLE_COUNT  out  32  number of CPU rising edges since reset
- BURST_REMAIN  out  BURST_WIDTH  CPU periods left in the current burst
- PC_SNAP  out  32  PC captured at the last CLK_OUT falling edge
- INST_SNAP  out  32  INST captured at the last CLK_OUT falling edge

## Operation
- States: HALT, RUN, STEP, BURST. All outputs are registered.
- Divider: the counter is cleared on every entry into RUN, STEP or BURST. It increments each cycle while not in HALT. A phase event occurs when counter == DIV; the counter then clears and CLK_OUT toggles.
  - DIV sampled at every phase event; mid-count changes apply from the next half-period.
  - DIV=0: a phase event occurs every cycle, giving CLK_OUT period 2.
- Button path:
  - 2-FF synchroniser, then debounce.
  - The debounced level changes only after the synchronised input has held a new value for DB_CYCLES consecutive cycles.
  - A press event is a single-cycle pulse on the debounced 0->1 transition.
- HALT:
  - CLK_OUT held 0; divider counter held 0.
  - MODE=00 -> RUN.
  - MODE=10 with a press event -> STEP.
  - MODE=11 with a press event and BURST_LEN != 0 -> BURST; BURST_REMAIN loads BURST_LEN.
  - MODE=11 with BURST_LEN=0 stays in HALT.
  - MODE=01 stays in HALT.
- RUN: toggles freely. On a falling phase event (CLK_OUT 1->0) with MODE != 00 -> HALT.
- STEP: exactly one CLK_OUT period (rise, then fall), then HALT. Press events while in STEP are ignored.
- BURST:
  - BURST_REMAIN decrements on each falling phase event.
  - On the falling event where BURST_REMAIN reaches 0 -> HALT.
  - MODE=01 at any falling event aborts -> HALT; BURST_REMAIN cleared to 0.
- The clock only ever stops with CLK_OUT = 0. A mode change while CLK_OUT = 1 completes the high phase first.
- Snapshot: PC_SNAP/INST_SNAP load PC_IN/INST_IN on every falling phase event.
- CYCLE_COUNT increments with each CLK_EN and wraps 0xFFFFFFFF -> 0.

## Timing
- Reset values, applied the cycle after RST is sampled high:
  - state HALT; CLK_OUT, CLK_EN, RUNNING = 0.
  - CYCLE_COUNT, BURST_REMAIN, PC_SNAP, INST_SNAP = 0.
  - divider, debounce counter and synchroniser flops = 0.
- RST asserted mid-operation overrides everything. CLK_OUT may drop from 1 to 0 directly on reset.
- HALT -> RUN one cycle after MODE=00 is seen. The first CLK_EN follows DIV+1 cycles after RUN entry, then every 2*(DIV+1) cycles.
- CLK_EN rises in the same cycle CLK_OUT becomes 1, and lasts exactly one CLK_GEN cycle.
- Button latency: 2 synchroniser cycles + DB_CYCLES to the press event, plus 1 cycle to STEP/BURST entry.
- RUNNING updates in the cycle the state register changes.
- Snapshot registers update in the cycle CLK_OUT becomes 0.

## Test plan
- Free-run: DIV=3, MODE=00 after reset -> CLK_EN at cycles 4, 12, 20 after RUN entry; CLK_OUT period 8; CYCLE_COUNT = 3 after cycle 20.
- Halt mid-high: MODE=00 -> 01 while CLK_OUT=1 -> CLK_OUT falls at the next phase event, RUNNING=0, no further CLK_EN; snapshot equals the PC_IN present at that fall.
- Single-step: DB_CYCLES=4, MODE=10, STEP_BTN with 3-cycle glitches then held 20 cycles:
  - glitches produce no step;
  - the hold produces exactly one CLK_EN and one CLK_OUT period, then HALT;
  - a second press during STEP is ignored.
- Burst: BURST_LEN=5, DIV=0, MODE=11, press -> exactly 5 CLK_EN pulses, BURST_REMAIN 5->0, RUNNING low after the 5th fall. Repeat with BURST_LEN=0 -> no CLK_EN.
- Burst abort: BURST_LEN=100, MODE->01 after 10 periods -> stop at the next fall, BURST_REMAIN=0, CYCLE_COUNT=10 or 11.
- Reset and wrap: force CYCLE_COUNT to 0xFFFFFFFF, one CLK_EN -> 0. Assert RST while CLK_OUT=1 -> next cycle all outputs 0, state HALT.
